// File: rtl/wb_retire_queue_pkg.sv
// Shared pipeline stage-bus definitions: MEM->WB bus width and field offsets.
// The bus is packed {excp, gr_we, dest, result, pc} with excp in the MSB.
package wb_retire_queue_pkg;

    localparam int DEF_DW  = 32;
    localparam int DEF_AW  = 5;
    localparam int DEF_PCW = 32;

    // Reference layout of the MEM->WB bus at the default widths.
    typedef struct packed {
        logic                excp;
        logic                gr_we;
        logic [DEF_AW-1:0]   dest;
        logic [DEF_DW-1:0]   result;
        logic [DEF_PCW-1:0]  pc;
    } wb_entry_t;

    function automatic int bus_width(input int aw, input int dw, input int pcw);
        return 2 + aw + dw + pcw;
    endfunction

    function automatic int off_pc();
        return 0;
    endfunction

    function automatic int off_result(input int pcw);
        return pcw;
    endfunction

    function automatic int off_dest(input int dw, input int pcw);
        return pcw + dw;
    endfunction

    function automatic int off_gr_we(input int aw, input int dw, input int pcw);
        return pcw + dw + aw;
    endfunction

    function automatic int off_excp(input int aw, input int dw, input int pcw);
        return pcw + dw + aw + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Read/write pointer and occupancy tracking for a power-of-two circular FIFO.
module sync_fifo_ptr #(
    parameter int DEPTH = 2,
    localparam int PTRW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    output logic [PTRW-1:0] rd_ptr,
    output logic [PTRW-1:0] wr_ptr,
    output logic [PTRW:0]   count,
    output logic            full
);

    localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full = (count == FULL_CNT);

endmodule

// File: rtl/wb_retire_queue.sv
// Write-back retire queue: buffers MEM results and retires them in order to the
// register file when its write port is free, flushing on an exception at head.
module wb_retire_queue
    import wb_retire_queue_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int PCW   = 32,
    parameter int DEPTH = 2,
    localparam int BUSW = bus_width(AW, DW, PCW)
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    ws_allowin,
    input  logic                    ms_to_ws_valid,
    input  logic [BUSW-1:0]         ms_to_ws_bus,
    input  logic                    rf_wready,
    output logic                    rf_we,
    output logic [AW-1:0]           rf_waddr,
    output logic [DW-1:0]           rf_wdata,
    output logic [2+AW+DW-1:0]      rf_bus,
    output logic [DEPTH*(1+AW)-1:0] pend_vec,
    output logic                    ws_excp_flush,
    output logic [PCW-1:0]          ws_excp_pc,
    output logic [31:0]             retire_cnt,
    output logic [PCW-1:0]          debug_wb_pc,
    output logic [DW/8-1:0]         debug_wb_rf_we,
    output logic [AW-1:0]           debug_wb_rf_wnum,
    output logic [DW-1:0]           debug_wb_rf_wdata
);

    localparam int PTRW     = $clog2(DEPTH);
    localparam int OFF_PC   = off_pc();
    localparam int OFF_RES  = off_result(PCW);
    localparam int OFF_DEST = off_dest(DW, PCW);
    localparam int OFF_GRWE = off_gr_we(AW, DW, PCW);
    localparam int OFF_EXCP = off_excp(AW, DW, PCW);

    logic [BUSW-1:0] entries [DEPTH];
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW:0]   count;
    logic            full;

    logic [BUSW-1:0] head;
    logic            head_valid;
    logic            head_excp;
    logic            head_gr_we;
    logic            push;
    logic            retire;

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (retire),
        .flush  (ws_excp_flush),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .count  (count),
        .full   (full)
    );

    assign head       = entries[rd_ptr];
    assign head_valid = (count != '0);
    assign head_excp  = head[OFF_EXCP];
    assign head_gr_we = head[OFF_GRWE];

    assign ws_allowin    = !full;
    assign ws_excp_flush = head_valid && head_excp;
    assign ws_excp_pc    = head[OFF_PC +: PCW];
    assign push          = ms_to_ws_valid && ws_allowin && !ws_excp_flush;
    assign retire        = head_valid && (head_excp || !head_gr_we || rf_wready);

    assign rf_we    = head_valid && head_gr_we && !head_excp && rf_wready;
    assign rf_waddr = head[OFF_DEST +: AW];
    assign rf_wdata = head[OFF_RES +: DW];
    assign rf_bus   = {head_valid, rf_we, rf_waddr, rf_wdata};

    assign debug_wb_pc       = head[OFF_PC +: PCW];
    assign debug_wb_rf_we    = {(DW/8){rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    // Storage is intentionally not reset; occupancy alone qualifies every slot.
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= ms_to_ws_bus;
    end

    always_ff @(posedge clk) begin
        if (reset)
            retire_cnt <= '0;
        else if (retire && !head_excp)
            retire_cnt <= retire_cnt + 32'd1;
    end

    // A slot is live when its distance from rd_ptr is below count; dest is
    // zeroed for dead slots so stale storage never shows up as a hazard.
    always_comb begin
        pend_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, PTRW'(PTRW'(i) - rd_ptr)} < count) && entries[i][OFF_GRWE])
                pend_vec[i*(1+AW) +: 1+AW] = {1'b1, entries[i][OFF_DEST +: AW]};
        end
    end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed and randomized checks of wb_retire_queue against a queue-based model.
module tb_wb_retire_queue;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int PCW   = 32;
    localparam int DEPTH = 2;
    localparam int BUSW  = 2 + AW + DW + PCW;

    logic                    clk;
    logic                    reset;
    logic                    ws_allowin;
    logic                    ms_to_ws_valid;
    logic [BUSW-1:0]         ms_to_ws_bus;
    logic                    rf_wready;
    logic                    rf_we;
    logic [AW-1:0]           rf_waddr;
    logic [DW-1:0]           rf_wdata;
    logic [2+AW+DW-1:0]      rf_bus;
    logic [DEPTH*(1+AW)-1:0] pend_vec;
    logic                    ws_excp_flush;
    logic [PCW-1:0]          ws_excp_pc;
    logic [31:0]             retire_cnt;
    logic [PCW-1:0]          debug_wb_pc;
    logic [DW/8-1:0]         debug_wb_rf_we;
    logic [AW-1:0]           debug_wb_rf_wnum;
    logic [DW-1:0]           debug_wb_rf_wdata;

    wb_retire_queue #(.DW(DW), .AW(AW), .PCW(PCW), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .rf_wready         (rf_wready),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .rf_bus            (rf_bus),
        .pend_vec          (pend_vec),
        .ws_excp_flush     (ws_excp_flush),
        .ws_excp_pc        (ws_excp_pc),
        .retire_cnt        (retire_cnt),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        excp;
        bit        gr_we;
        bit [4:0]  dest;
        bit [31:0] result;
        bit [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    int unsigned mhead;
    bit [31:0]   mcnt;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(bit excp, bit gr_we, bit [4:0] dest, bit [31:0] result, bit [31:0] pc);
        ent_t e;
        e.excp = excp; e.gr_we = gr_we; e.dest = dest; e.result = result; e.pc = pc;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        return mk($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                  5'($urandom), $urandom, $urandom);
    endfunction

    // One cycle: drive inputs, compare predicted outputs, clock, advance model.
    task automatic step(input bit v, input ent_t e, input bit wr);
        bit   hv, flush, ret, exp_we, push;
        ent_t h;
        logic [DEPTH*(1+AW)-1:0] pv;
        ms_to_ws_valid = v;
        ms_to_ws_bus   = {e.excp, e.gr_we, e.dest, e.result, e.pc};
        rf_wready      = wr;
        #1;
        hv = (mq.size() != 0);
        h  = hv ? mq[0] : mk(0, 0, 0, 0, 0);
        flush  = hv && h.excp;
        ret    = hv && (h.excp || !h.gr_we || wr);
        exp_we = hv && h.gr_we && !h.excp && wr;
        push   = v && (mq.size() != DEPTH) && !flush;
        pv = '0;
        foreach (mq[k])
            if (mq[k].gr_we) pv[((mhead + k) % DEPTH)*(1+AW) +: 1+AW] = {1'b1, mq[k].dest};

        chk("allowin", ws_allowin, mq.size() != DEPTH);
        chk("rf_we", rf_we, exp_we);
        chk("excp_flush", ws_excp_flush, flush);
        chk("head_valid", rf_bus[2+AW+DW-1], hv);
        chk("pend_vec", pend_vec, pv);
        chk("retire_cnt", retire_cnt, mcnt);
        chk("dbg_rf_we", debug_wb_rf_we, {(DW/8){exp_we}});
        if (hv) begin
            chk("rf_bus", rf_bus, {hv, exp_we, h.dest, h.result});
            chk("rf_waddr", rf_waddr, h.dest);
            chk("rf_wdata", rf_wdata, h.result);
            chk("dbg_pc", debug_wb_pc, h.pc);
            chk("dbg_wnum", debug_wb_rf_wnum, h.dest);
            chk("dbg_wdata", debug_wb_rf_wdata, h.result);
            if (flush) chk("excp_pc", ws_excp_pc, h.pc);
        end

        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
            mhead = 0;
        end else begin
            if (ret) begin
                void'(mq.pop_front());
                mhead = (mhead + 1) % DEPTH;
                mcnt  = mcnt + 32'd1;
            end
            if (push) mq.push_back(e);
        end
    endtask

    task automatic do_reset(input bit v);
        reset          = 1'b1;
        ms_to_ws_valid = v;
        rf_wready      = 1'b0;
        #1;
        chk("rst_no_we", rf_we, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        mhead = 0;
        mcnt  = '0;
    endtask

    ent_t idle;

    initial begin
        checks = 0;
        errors = 0;
        mhead  = 0;
        mcnt   = '0;
        idle   = mk(0, 0, 0, 0, 0);
        reset  = 1'b1;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus   = '0;
        rf_wready      = 1'b0;
        @(posedge clk);
        #1;
        do_reset(0);
        step(0, idle, 0);

        // Single gr_we entry retires the cycle after enqueue.
        step(1, mk(0, 1, 5'd5, 32'h1234, 32'h1C00_0000), 1);
        step(0, idle, 1);
        step(0, idle, 1);

        // Backpressure: third entry waits at MEM while the queue is full.
        step(1, mk(0, 1, 5'd1, 32'hA1, 32'h100), 0);
        step(1, mk(0, 1, 5'd2, 32'hA2, 32'h104), 0);
        step(1, mk(0, 1, 5'd3, 32'hA3, 32'h108), 0);
        step(1, mk(0, 1, 5'd3, 32'hA3, 32'h108), 0);
        step(1, mk(0, 1, 5'd3, 32'hA3, 32'h108), 1);
        step(1, mk(0, 1, 5'd3, 32'hA3, 32'h108), 1);
        step(0, idle, 1);
        step(0, idle, 1);

        // gr_we=0 entry retires regardless of rf_wready.
        step(1, mk(0, 0, 5'd7, 32'h77, 32'h200), 0);
        step(0, idle, 0);
        step(0, idle, 0);

        // Exception reaches head while MEM presents another entry.
        step(1, mk(0, 1, 5'd9, 32'h99, 32'h1C00_003C), 0);
        step(1, mk(1, 1, 5'd3, 32'h33, 32'h1C00_0040), 0);
        step(1, mk(0, 1, 5'd4, 32'h44, 32'h1C00_0044), 1);
        step(1, mk(0, 1, 5'd4, 32'h44, 32'h1C00_0044), 1);
        step(0, idle, 1);

        // retire_cnt wrap.
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        mcnt = 32'hFFFF_FFFF;
        step(1, mk(0, 0, 5'd1, 32'h1, 32'h300), 1);
        step(0, idle, 1);
        step(0, idle, 1);

        // Reset with a full queue.
        step(1, mk(0, 1, 5'd10, 32'hB0, 32'h400), 0);
        step(1, mk(0, 1, 5'd11, 32'hB1, 32'h404), 0);
        step(1, mk(0, 1, 5'd12, 32'hB2, 32'h408), 0);
        do_reset(1);
        step(0, idle, 1);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset($urandom_range(0, 1) == 1);
            else
                step($urandom_range(0, 9) < 7, rnd_ent(), $urandom_range(0, 1) == 1);
        end
        step(0, idle, 1);
        step(0, idle, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
